// File: rtl/iter_alu.sv
// iter_alu: registered ALU with an optional iterative unsigned multiply/divide unit.
// Single-cycle ops complete one cycle after issue. Op codes 10xx run for WIDTH cycles
// when the macro ITER_ALU_MULDIV_EN is defined; without it they return 0 in one cycle.
module iter_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic             accept;
    logic             is_iter;
    logic             iter_last;
    logic [WIDTH-1:0] iter_res;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] result_q;

    // New work is taken in IDLE and DONE; RUN ignores start
    assign accept = start && (state_q != StRun);

`ifdef ITER_ALU_MULDIV_EN
    logic [SHW-1:0]     cnt_q;
    // Shared accumulator: mul = {product hi, multiplier/product lo}, div = {remainder, quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand for mul, divisor for div
    logic [WIDTH-1:0]   opnd_q;
    logic [1:0]         mop_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;

    assign is_iter = (op[3:2] == 2'b10);

    // One shift-add or restoring-divide step per RUN cycle
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        acc_d     = acc_q;
        if (!mop_q[1]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            // Dropped remainder MSB is always 0 here: a set MSB would never borrow
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    assign iter_last = (state_q == StRun) && (cnt_q == '0);
    // mulhu/remu take the upper half, mul/divu the lower half
    assign iter_res  = mop_q[0] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

    // Capture operands on accept, then iterate while in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            mop_q  <= '0;
        end else if (accept && is_iter) begin
            cnt_q  <= SHW'(WIDTH - 1);
            acc_q  <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            opnd_q <= op[1] ? b : a;
            mop_q  <= op[1:0];
        end else if (state_q == StRun) begin
            cnt_q  <= cnt_q - SHW'(1);
            acc_q  <= acc_d;
        end
    end
`else
    assign is_iter   = 1'b0;
    assign iter_last = 1'b0;
    assign iter_res  = '0;
`endif

    // Single-cycle datapath; 10xx and 11xx fall through to zero
    always_comb begin
        alu_out = '0;
        case (op)
            4'b0000: alu_out = a + b;
            4'b0001: alu_out = a - b;
            4'b0010: alu_out = a & b;
            4'b0011: alu_out = a | b;
            4'b0100: alu_out = a << b[SHW-1:0];
            4'b0101: alu_out = a >> b[SHW-1:0];
            4'b0110: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b0111: alu_out = a ^ b;
            default: alu_out = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = is_iter ? StRun : StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (iter_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result register, written only on the edge that enters DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else if (accept && !is_iter) begin
            result_q <= alu_out;
        end else if (iter_last) begin
            result_q <= iter_res;
        end
    end

    // Outputs decoded from registered state and result
    always_comb begin
`ifdef ITER_ALU_MULDIV_EN
        busy = (state_q == StRun);
`else
        busy = 1'b0;
`endif
        done   = (state_q == StDone);
        result = result_q;
        zero   = (result_q == '0);
    end

endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised, registered successor to the core's single-cycle ALU. It adds an iterative unsigned multiply/divide unit behind a start/done handshake and generalises the datapath width. It sits in the EX stage: the hazard unit stalls the pipeline while `busy` is high. Single-cycle ops keep the existing 3-bit encodings and complete one cycle after issue.

## Interface
- `WIDTH`, 32, datapath width in bits; must be ≥ 8 and a power of two.
- `SHW`, $clog2(WIDTH), derived shift-amount width; not overridden.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue request; accepted only when `busy`=0.
- `op`  in  4  operation code, sampled on accept.
- `a`, `b`  in  WIDTH  operands, sampled on accept.
- `busy`  out  1  high while an iterative op is running.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH  registered result; held until the next completion.
- `zero`  out  1  `result == 0`, derived from the registered result.

## Operation
- Op codes:
  - 0000 add; 0001 sub; 0010 and; 0011 or.
  - 0100 sll, using `b[SHW-1:0]` as the shift amount; 0101 srl, same shift amount.
  - 0110 slt, unsigned compare, result 1/0 zero-extended; 0111 xor.
  - 1000 mul: low WIDTH bits of a×b.
  - 1001 mulhu: high WIDTH bits of a×b.
  - 1010 divu; 1011 remu.
  - 11xx: result 0, single-cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + `start` + single-cycle op → DONE.
  - IDLE/DONE + `start` + op 10xx → RUN; iteration counter loaded with WIDTH-1.
  - IDLE/DONE without `start`: DONE → IDLE; IDLE stays IDLE.
  - RUN: one iteration per cycle. When the counter reaches 0 → DONE.
- Multiply: shift-add, 2·WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring divider, one quotient bit per cycle, MSB first. Remainder and quotient registers are WIDTH bits.
- Divide by zero takes normal RUN timing. Results: divu = all ones; remu = `a`.
- All arithmetic is unsigned and modulo 2^WIDTH. Carries and borrows are discarded.
- `start` while `busy`=1 is ignored. Operands and op are captured only on accept, so input changes during RUN have no effect.
- `done` is high exactly in DONE.
- `result` and `zero` update only on entry to DONE. They hold through IDLE and RUN.
- `reset` asserted at any time, including mid-RUN:
  - state → IDLE, `busy`=0, `done`=0, `result`=0, `zero`=1.
  - The in-flight op is discarded and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `zero`=1.
- Single-cycle op accepted at edge N: `done`=1 and `result` valid after edge N+1. Throughput is 1 op/cycle, because `start` is accepted in DONE.
- Iterative op accepted at edge N:
  - `busy`=1 after edges N+1 … N+WIDTH.
  - `done`=1 after edge N+WIDTH+1, with `busy`=0 in that cycle.
  - Latency is WIDTH+1 cycles.
- Back-to-back: `start` asserted in the DONE cycle is accepted at the same edge that leaves DONE. No bubble is inserted.
- `busy` is a registered output, fully decoded from state. There is no combinational path from `start` to `busy` or `done`.

## Configuration
- `ITER_ALU_MULDIV_EN` defined: op codes 10xx run as described.
- `ITER_ALU_MULDIV_EN` undefined:
  - The counter, accumulator and divider registers are not built, and RUN is unreachable.
  - Op codes 10xx behave like 11xx: result 0, single-cycle.
  - `busy` is tied to 0.

## Test plan
- Reset then idle: `result`=0, `zero`=1, `busy`=0, `done`=0. Then add a=5, b=7 → `done` one cycle later, `result`=12, `zero`=0.
- Back-to-back single-cycle ops on consecutive cycles: sub 3−3 → 0 with `zero`=1; sll 1<<33 (WIDTH=32) → 2; slt 2<3 → 1. Each `done` follows its issue by one cycle, with no gaps.
- mul 0xFFFF_FFFF × 2 → `result` 0xFFFF_FFFE after 33 cycles, `busy` high for 32. mulhu with the same operands → 1.
- divu 100/7 → 14; remu 100/7 → 2. divu x/0 → 0xFFFF_FFFF; remu 9/0 → 9. `start` pulsed during RUN is ignored and causes no extra `done`.
- Reset asserted at RUN cycle 10 of a divu: outputs immediately return to reset values. No `done` follows, and a new add issued after release completes normally.
- Build without `ITER_ALU_MULDIV_EN`: mul 6×7 → `result` 0 one cycle later, `busy` never asserted.
